// File: rtl/reg_file.sv
// reg_file: architectural register file plus rename-tag table.
// The issue stage reads register values, or the ROB tags that rename them.
// The issue stage also renames rd to a newly allocated ROB tag.
// A ROB commit writes the value. It clears the rename only if the tag still matches.
// A flush clears every rename.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a read of a busy register that is committing this cycle with a
//   matching tag returns Commit_V with busy=0 in the same cycle.
//   When undefined, reads show the pre-commit state.
//
// Ports:
//   clk_in, rst_in         clock, synchronous active-high reset
//   rdy_in                 1 = advance, 0 = hold all state
//   rs1_addr, rs2_addr     issue read indices
//   V1/V2, Q1/Q2, busy1/2  read value, rename tag, pending flag (combinational)
//   issue_en/rd/Q          rename rd to the ROB tag issue_Q
//   has_commit, commit_rd,
//   Commit_Q, Commit_V     ROB commit of one entry
//   flush                  misprediction: drop all renames
module reg_file #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned Q_WIDTH        = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [31:0]               V1,
    output logic [31:0]               V2,
    output logic [Q_WIDTH-1:0]        Q1,
    output logic [Q_WIDTH-1:0]        Q2,
    output logic                      busy1,
    output logic                      busy2,
    input  logic                      issue_en,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [Q_WIDTH-1:0]        issue_Q,
    input  logic                      has_commit,
    input  logic [REG_ADDR_WIDTH-1:0] commit_rd,
    input  logic [Q_WIDTH-1:0]        Commit_Q,
    input  logic [31:0]               Commit_V,
    input  logic                      flush
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [31:0]        val  [NUM_REGS];
    logic [Q_WIDTH-1:0] tag  [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic commit_ok;
    logic issue_ok;

    assign commit_ok = has_commit && (commit_rd != '0);
    assign issue_ok  = issue_en && (issue_rd != '0) && !flush;

    // State update. The issue assignment comes after the commit assignment,
    // so an issue wins busy/tag when both target the same rd.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
            busy <= '0;
        end else if (rdy_in) begin
            if (commit_ok) begin
                val[commit_rd] <= Commit_V;
                // A stale commit must not clear a newer rename.
                if (tag[commit_rd] == Commit_Q) begin
                    busy[commit_rd] <= 1'b0;
                end
            end
            if (flush) begin
                busy <= '0;
            end else if (issue_ok) begin
                busy[issue_rd] <= 1'b1;
                tag[issue_rd]  <= issue_Q;
            end
        end
    end

    // Read port 1. x0 always reads as zero and not busy.
    always_comb begin
        V1    = '0;
        Q1    = '0;
        busy1 = 1'b0;
        if (rs1_addr != '0) begin
            V1    = val[rs1_addr];
            Q1    = tag[rs1_addr];
            busy1 = busy[rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (rdy_in && commit_ok && (commit_rd == rs1_addr) &&
                busy[rs1_addr] && (tag[rs1_addr] == Commit_Q)) begin
                V1    = Commit_V;
                busy1 = 1'b0;
            end
`else
`endif
        end
    end

    // Read port 2. Same rules as port 1.
    always_comb begin
        V2    = '0;
        Q2    = '0;
        busy2 = 1'b0;
        if (rs2_addr != '0) begin
            V2    = val[rs2_addr];
            Q2    = tag[rs2_addr];
            busy2 = busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (rdy_in && commit_ok && (commit_rd == rs2_addr) &&
                busy[rs2_addr] && (tag[rs2_addr] == Commit_Q)) begin
                V2    = Commit_V;
                busy2 = 1'b0;
            end
`else
`endif
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: each step drives inputs and then checks
// the reads against values computed by hand.
module tb_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] V1, V2;
    logic [4:0]  Q1, Q2;
    logic        busy1, busy2;
    logic        issue_en;
    logic [4:0]  issue_rd, issue_Q;
    logic        has_commit;
    logic [4:0]  commit_rd, Commit_Q;
    logic [31:0] Commit_V;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    reg_file #(.REG_ADDR_WIDTH(5), .Q_WIDTH(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .V1(V1), .V2(V2), .Q1(Q1), .Q2(Q2), .busy1(busy1), .busy2(busy2),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_Q(issue_Q),
        .has_commit(has_commit), .commit_rd(commit_rd),
        .Commit_Q(Commit_Q), .Commit_V(Commit_V), .flush(flush)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Advance one clock, then drop the single-cycle controls.
    task automatic tick();
        @(posedge clk_in);
        #1;
        issue_en   = 1'b0;
        has_commit = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    task automatic do_issue(input logic [4:0] r, input logic [4:0] q);
        issue_en = 1'b1; issue_rd = r; issue_Q = q;
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [4:0] q, input logic [31:0] v);
        has_commit = 1'b1; commit_rd = r; Commit_Q = q; Commit_V = v;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rs1_addr = '0; rs2_addr = '0;
        issue_en = 1'b0; issue_rd = '0; issue_Q = '0;
        has_commit = 1'b0; commit_rd = '0; Commit_Q = '0; Commit_V = '0;
        flush = 1'b0;
        tick(); tick();
        rst_in = 1'b0;

        // 1: reset state and x0 writes
        rd(5'd5, 5'd31);
        chk("rst_v1", V1, 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        chk("rst_q1", 32'(Q1), 32'h0);
        chk("rst_busy2", 32'(busy2), 32'h0);
        do_commit(5'd0, 5'd0, 32'h7);
        do_issue(5'd0, 5'd3);
        tick();
        rd(5'd0, 5'd0);
        chk("x0_v1", V1, 32'h0);
        chk("x0_busy1", 32'(busy1), 32'h0);
        chk("x0_q1", 32'(Q1), 32'h0);

        // 2: rename and matching commit
        do_issue(5'd3, 5'd4);
        tick();
        rd(5'd3, 5'd0);
        chk("iss_busy", 32'(busy1), 32'h1);
        chk("iss_q", 32'(Q1), 32'h4);
        do_commit(5'd3, 5'd4, 32'h55);
        tick();
        rd(5'd3, 5'd0);
        chk("cmt_busy", 32'(busy1), 32'h0);
        chk("cmt_v", V1, 32'h55);

        // 3: stale commit keeps the newer rename
        do_issue(5'd3, 5'd4);
        tick();
        do_issue(5'd3, 5'd9);
        tick();
        do_commit(5'd3, 5'd4, 32'h1);
        tick();
        rd(5'd0, 5'd3);
        chk("stale_v", V2, 32'h1);
        chk("stale_busy", 32'(busy2), 32'h1);
        chk("stale_q", 32'(Q2), 32'h9);

        // 4: issue and commit to the same rd in one cycle
        do_issue(5'd7, 5'd2);
        do_commit(5'd7, 5'd2, 32'h8);
        tick();
        rd(5'd7, 5'd0);
        chk("same_v", V1, 32'h8);
        chk("same_busy", 32'(busy1), 32'h1);
        chk("same_q", 32'(Q1), 32'h2);

        // 5: flush drops renames and the same-cycle issue; commit still writes
        do_issue(5'd1, 5'd10);
        tick();
        do_issue(5'd2, 5'd11);
        tick();
        rd(5'd1, 5'd2);
        chk("pre_fl_busy1", 32'(busy1), 32'h1);
        chk("pre_fl_busy2", 32'(busy2), 32'h1);
        flush = 1'b1;
        do_issue(5'd4, 5'd12);
        do_commit(5'd1, 5'd10, 32'h3);
        tick();
        rd(5'd1, 5'd2);
        chk("fl_v1", V1, 32'h3);
        chk("fl_busy1", 32'(busy1), 32'h0);
        chk("fl_busy2", 32'(busy2), 32'h0);
        rd(5'd4, 5'd7);
        chk("fl_x4_busy", 32'(busy1), 32'h0);
        chk("fl_x4_q", 32'(Q1), 32'h0);
        chk("fl_x7_busy", 32'(busy2), 32'h0);
        rd(5'd3, 5'd0);
        chk("fl_x3_busy", 32'(busy1), 32'h0);

        // 6: rdy_in=0 holds all state
        do_issue(5'd5, 5'd3);
        tick();
        rdy_in = 1'b0;
        do_issue(5'd6, 5'd7);
        do_commit(5'd5, 5'd3, 32'h99);
        tick();
        rdy_in = 1'b1;
        rd(5'd5, 5'd6);
        chk("hold_v", V1, 32'h0);
        chk("hold_busy", 32'(busy1), 32'h1);
        chk("hold_q", 32'(Q1), 32'h3);
        chk("hold_x6_busy", 32'(busy2), 32'h0);

        // Same-cycle read of a committing register
        do_issue(5'd6, 5'd1);
        tick();
        do_commit(5'd6, 5'd1, 32'hA);
        rd(5'd6, 5'd0);
`ifdef REGFILE_BYPASS_EN
        chk("byp_v", V1, 32'hA);
        chk("byp_busy", 32'(busy1), 32'h0);
`else
        chk("nobyp_v", V1, 32'h0);
        chk("nobyp_busy", 32'(busy1), 32'h1);
        chk("nobyp_q", 32'(Q1), 32'h1);
`endif
        tick();
        rd(5'd6, 5'd0);
        chk("after_byp_v", V1, 32'hA);
        chk("after_byp_busy", 32'(busy1), 32'h0);

        // Reset overrides rdy_in=0
        rdy_in = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        rd(5'd1, 5'd5);
        chk("rst2_v1", V1, 32'h0);
        chk("rst2_busy2", 32'(busy2), 32'h0);
        chk("rst2_q2", 32'(Q2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
